// File: rtl/glove_pos_tracker.sv
// glove_pos_tracker: multi-glove position integrator.
// A rate divider produces periodic update ticks. On each tick every glove moves
// per axis with hold-to-accelerate stepping (slow steps first, fast steps after
// ACCEL_TICKS consecutive held ticks), clamped to the configured play area.
// Optional feature macro: GLOVE_VEL_OUT_EN adds the 'vel' output carrying the
// signed per-axis delta applied on the last tick.
module glove_pos_tracker #(
   parameter int NUM_GLOVES     = 2,
   parameter int COORD_W        = 16,
   parameter int TICK_DIV       = 210937,
   parameter int STEP_SLOW      = 15,
   parameter int STEP_FAST      = 60,
   parameter int ACCEL_TICKS    = 4,
   parameter int X_INIT_BASE    = 2000,
   parameter int X_INIT_SPACING = 6000,
   parameter int Y_INIT         = 2000,
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 10000,
   parameter int Y_MIN          = 0,
   parameter int Y_MAX          = 3000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_GLOVES-1:0]           btn_right,
   input  logic [NUM_GLOVES-1:0]           btn_left,
   input  logic [NUM_GLOVES-1:0]           btn_up,
   input  logic [NUM_GLOVES-1:0]           btn_down,
   input  logic                            recenter,
   output logic [NUM_GLOVES*COORD_W-1:0]   glob_x,
   output logic [NUM_GLOVES*COORD_W-1:0]   glob_y,
   output logic                            tick,
   output logic [NUM_GLOVES-1:0]           moving
`ifdef GLOVE_VEL_OUT_EN
   ,
   output logic [NUM_GLOVES*2*COORD_W-1:0] vel
`endif
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;
   localparam int SUM_W = COORD_W + 2;

   localparam logic [DIV_W-1:0]   DIV_RELOAD = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ACCEL_TICKS - 1);
   localparam logic [COORD_W-1:0] STEP_S     = COORD_W'(STEP_SLOW);
   localparam logic [COORD_W-1:0] STEP_F     = COORD_W'(STEP_FAST);
   localparam logic [COORD_W-1:0] XLO        = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] XHI        = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] YLO        = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] YHI        = COORD_W'(Y_MAX);
   localparam logic [COORD_W-1:0] Y_START    = COORD_W'(Y_INIT);

   typedef enum logic [1:0] {IDLE = 2'd0, SLOW = 2'd1, FAST = 2'd2} state_t;

   // Initial x position of glove idx.
   function automatic logic [COORD_W-1:0] init_x(input int idx);
      return COORD_W'(X_INIT_BASE + idx * X_INIT_SPACING);
   endfunction

   // Direction from a pair of opposing requests; both or neither gives 0.
   function automatic logic signed [1:0] axis_dir(input logic pos, input logic neg);
      logic signed [1:0] d;
      case ({pos, neg})
         2'b10:   d = 2'sd1;
         2'b01:   d = -2'sd1;
         default: d = 2'sd0;
      endcase
      return d;
   endfunction

   // Signed add of one step in the given direction, clamped to [lo, hi].
   function automatic logic [COORD_W-1:0] step_axis(
      input logic [COORD_W-1:0] old,
      input logic signed [1:0]  d,
      input logic [COORD_W-1:0] step,
      input logic [COORD_W-1:0] lo,
      input logic [COORD_W-1:0] hi
   );
      logic signed [SUM_W-1:0] old_e;
      logic signed [SUM_W-1:0] step_e;
      logic signed [SUM_W-1:0] sum;
      logic [COORD_W-1:0]      res;
      old_e  = $signed({2'b00, old});
      step_e = $signed({2'b00, step});
      case (d)
         2'sd1:   sum = old_e + step_e;
         -2'sd1:  sum = old_e - step_e;
         default: sum = old_e;
      endcase
      if (sum < $signed({2'b00, lo})) begin
         res = lo;
      end else if (sum > $signed({2'b00, hi})) begin
         res = hi;
      end else begin
         res = sum[COORD_W-1:0];
      end
      return res;
   endfunction

   logic [DIV_W-1:0] div_r;
   logic             tick_r;
   logic             tick_en;

   assign tick_en = (div_r == {DIV_W{1'b0}});
   assign tick    = tick_r;

   // Update-rate divider: counts down, reloads at zero and flags the tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r  <= DIV_RELOAD;
         tick_r <= 1'b0;
      end else begin
         if (tick_en) begin
            div_r <= DIV_RELOAD;
         end else begin
            div_r <= div_r - DIV_W'(1);
         end
         tick_r <= tick_en;
      end
   end

   for (genvar g = 0; g < NUM_GLOVES; g++) begin : gen_glove
      localparam logic [COORD_W-1:0] X_START = init_x(g);

      state_t             state_r;
      logic [CNT_W-1:0]   cnt_r;
      logic [COORD_W-1:0] x_r;
      logic [COORD_W-1:0] y_r;
      logic               moving_r;
      logic signed [1:0]  dx;
      logic signed [1:0]  dy;
      logic               active;
      logic [COORD_W-1:0] step;
      logic [COORD_W-1:0] nx;
      logic [COORD_W-1:0] ny;

      // Direction decode and candidate next position for this glove.
      always_comb begin
         dx     = axis_dir(btn_right[g], btn_left[g]);
         dy     = axis_dir(btn_up[g], btn_down[g]);
         active = (dx != 2'sd0) || (dy != 2'sd0);
         if (state_r == FAST) begin
            step = STEP_F;
         end else begin
            step = STEP_S;
         end
         nx = step_axis(x_r, dx, step, XLO, XHI);
         ny = step_axis(y_r, dy, step, YLO, YHI);
      end

`ifdef GLOVE_VEL_OUT_EN
      logic [COORD_W-1:0] vx_r;
      logic [COORD_W-1:0] vy_r;

      // Applied per-axis delta from the most recent tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vx_r <= {COORD_W{1'b0}};
            vy_r <= {COORD_W{1'b0}};
         end else if (recenter) begin
            vx_r <= {COORD_W{1'b0}};
            vy_r <= {COORD_W{1'b0}};
         end else if (tick_en) begin
            if (active) begin
               vx_r <= nx - x_r;
               vy_r <= ny - y_r;
            end else begin
               vx_r <= {COORD_W{1'b0}};
               vy_r <= {COORD_W{1'b0}};
            end
         end
      end

      assign vel[(2*g)*COORD_W +: COORD_W]   = vx_r;
      assign vel[(2*g+1)*COORD_W +: COORD_W] = vy_r;
`endif

      // Accel FSM and position registers; recenter outranks the tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            x_r      <= X_START;
            y_r      <= Y_START;
            moving_r <= 1'b0;
         end else if (recenter) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            x_r      <= X_START;
            y_r      <= Y_START;
            moving_r <= 1'b0;
         end else if (tick_en) begin
            if (!active) begin
               state_r  <= IDLE;
               cnt_r    <= {CNT_W{1'b0}};
               moving_r <= 1'b0;
            end else begin
               x_r      <= nx;
               y_r      <= ny;
               moving_r <= 1'b1;
               case (state_r)
                  IDLE: begin
                     cnt_r <= CNT_W'(1);
                     if (ACCEL_TICKS <= 1) begin
                        state_r <= FAST;
                     end else begin
                        state_r <= SLOW;
                     end
                  end
                  SLOW: begin
                     if (cnt_r == CNT_LAST) begin
                        state_r <= FAST;
                     end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                     end
                  end
                  FAST: begin
                     state_r <= FAST;
                  end
                  default: begin
                     state_r <= IDLE;
                     cnt_r   <= {CNT_W{1'b0}};
                  end
               endcase
            end
         end
      end

      assign glob_x[g*COORD_W +: COORD_W] = x_r;
      assign glob_y[g*COORD_W +: COORD_W] = y_r;
      assign moving[g]                    = moving_r;
   end

endmodule

// File: tb/tb_glove_pos_tracker.sv
// tb_glove_pos_tracker: table-driven bench for glove_pos_tracker with a short
// tick period, a tight x ceiling for glove 1 and a raised y floor for glove 0.
module tb_glove_pos_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  btn_right, btn_left, btn_up, btn_down;
   logic        recenter;
   logic [31:0] glob_x, glob_y;
   logic        tick;
   logic [1:0]  moving;
`ifdef GLOVE_VEL_OUT_EN
   logic [63:0] vel;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   glove_pos_tracker #(
      .TICK_DIV (4),
      .X_MAX    (8020),
      .Y_MIN    (1990)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_right (btn_right),
      .btn_left  (btn_left),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .recenter  (recenter),
      .glob_x    (glob_x),
      .glob_y    (glob_y),
      .tick      (tick),
      .moving    (moving)
`ifdef GLOVE_VEL_OUT_EN
      ,
      .vel       (vel)
`endif
   );

   typedef struct {
      logic [1:0]  r, l, u, d;
      logic        rec;
      logic [15:0] x0, y0, x1, y1;
      logic [1:0]  mv;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] r, input logic [1:0] l, input logic [1:0] u,
                      input logic [1:0] d, input logic rec,
                      input int x0, input int y0, input int x1, input int y1,
                      input logic [1:0] mv);
      vec_t v;
      v.r = r; v.l = l; v.u = u; v.d = d; v.rec = rec;
      v.x0 = 16'(x0); v.y0 = 16'(y0); v.x1 = 16'(x1); v.y1 = 16'(y1);
      v.mv = mv;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic chk_pos(input int idx, input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] x1, input logic [15:0] y1,
                          input logic [1:0] mv);
      chk("x0", idx, {16'd0, glob_x[15:0]}, {16'd0, x0});
      chk("y0", idx, {16'd0, glob_y[15:0]}, {16'd0, y0});
      chk("x1", idx, {16'd0, glob_x[31:16]}, {16'd0, x1});
      chk("y1", idx, {16'd0, glob_y[31:16]}, {16'd0, y1});
      chk("moving", idx, {30'd0, moving}, {30'd0, mv});
   endtask

   // Wait (bounded) for the next tick pulse, returning negedges waited.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 12);
   endtask

   initial begin
      int n;
      reset = 1'b1; recenter = 1'b0;
      btn_right = 2'b00; btn_left = 2'b00; btn_up = 2'b00; btn_down = 2'b00;

      // Table: state carries over from entry to entry.
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2015, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2030, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2045, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2060, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2120, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8000, 2000, 2'b01);
      add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8000, 2000, 2'b00);
      add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8015, 2000, 2'b10);
      add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8020, 2000, 2'b10);
      add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8020, 2000, 2'b10);
      add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 2000, 8020, 2000, 2'b00);
      add(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2180, 1990, 8020, 2000, 2'b01);
      add(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2180, 1990, 8020, 2000, 2'b01);
      add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2180, 1990, 8020, 2000, 2'b00);
      add(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2180, 1990, 8020, 2000, 2'b00);
      add(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 2195, 2005, 8020, 2000, 2'b01);
      add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2195, 2005, 8020, 2000, 2'b00);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2210, 2005, 8020, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2000, 2000, 8000, 2000, 2'b00);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2015, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2030, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2045, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2060, 2000, 8000, 2000, 2'b01);
      add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2120, 2000, 8000, 2000, 2'b01);

      // Reset state.
      repeat (3) @(negedge clk);
      chk_pos(-1, 16'd2000, 16'd2000, 16'd8000, 16'd2000, 2'b00);
      chk("tick_rst", -1, {31'd0, tick}, 32'd0);
      reset = 1'b0;

      // First tick after release, no buttons: nothing moves.
      wait_tick(n);
      chk("first_tick", -1, n, 4);
      chk_pos(-1, 16'd2000, 16'd2000, 16'd8000, 16'd2000, 2'b00);

      foreach (tbl[i]) begin
         btn_right = tbl[i].r; btn_left = tbl[i].l;
         btn_up    = tbl[i].u; btn_down = tbl[i].d;
         if (tbl[i].rec) begin
            // Land recenter on the cycle the divider fires.
            repeat (3) @(negedge clk);
            recenter = 1'b1;
            @(negedge clk);
            recenter = 1'b0;
            n = 4;
            while (!tick && n < 12) begin
               @(negedge clk);
               n++;
            end
         end else begin
            wait_tick(n);
         end
         chk("tick_gap", i, n, 4);
         chk_pos(i, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].mv);
      end

      // Reset in the middle of a FAST hold: immediate return to init.
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_pos(100, 16'd2000, 16'd2000, 16'd8000, 16'd2000, 2'b00);
      chk("tick_midrst", 100, {31'd0, tick}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      // Still holding right: restarts from IDLE with a slow step.
      wait_tick(n);
      chk("tick_after_rst", 101, n, 4);
      chk_pos(101, 16'd2015, 16'd2000, 16'd8000, 16'd2000, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
